// File: rtl/f1_start_sequencer.sv
// ---------------------------------------------------------------------------
// f1_start_sequencer
//   F1-style start-light sequencer with reaction timer.
//   Ten lights come on one by one, a pseudo-random hold follows, then all
//   lights go out and the driver's reaction time is counted in ticks.
//
//   Optional build macro: F1_JUMP_DETECT_EN
//     defined   -> a button press while the lights are running aborts the
//                  sequence into JUMP (all lights on, jump_start flag set).
//     undefined -> such presses are ignored and JUMP is never entered.
//
//   state_dbg exposes the FSM state encoding for observation.
//
//   Handshake note: there is no back-pressure anywhere. trigger and react
//   are level inputs reduced to single-cycle rising edges internally; valid
//   is a one-cycle strobe qualifying react_ms, and react_ms then holds its
//   value until the next start.
// ---------------------------------------------------------------------------
module f1_start_sequencer #(
  parameter int LIGHT_TICKS = 500,
  parameter int MIN_DELAY   = 200,
  parameter int MAX_REACT   = 9999
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        trigger,
  input  logic        react,
  input  logic [9:0]  lfsr_val,
  output logic        en_lfsr,
  output logic [9:0]  ledr,
  output logic [13:0] react_ms,
  output logic        valid,
  output logic        jump_start,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LIGHTS = 3'd1;
  localparam logic [2:0] ST_DELAY  = 3'd2;
  localparam logic [2:0] ST_GO     = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_JUMP   = 3'd5;

  localparam logic [13:0] LT_LAST = 14'(LIGHT_TICKS - 1);
  localparam logic [13:0] MIN_D   = 14'(MIN_DELAY);
  localparam logic [13:0] MAX_R   = 14'(MAX_REACT);
  localparam logic [3:0]  STEP_LAST = 4'd9;

  logic [2:0]  state_q,     state_d;
  logic [9:0]  ledr_q,      ledr_d;
  logic [13:0] react_ms_q,  react_ms_d;
  logic        valid_q,     valid_d;
  logic        jump_q,      jump_d;
  logic [3:0]  step_q,      step_d;
  logic [13:0] tick_cnt_q,  tick_cnt_d;
  logic [13:0] react_cnt_q, react_cnt_d;
  logic [13:0] delay_q,     delay_d;
  logic        trig_hist_q, trig_hist_d;
  logic        react_hist_q, react_hist_d;
  logic        armed_q,     armed_d;

  logic trig_edge;
  logic react_edge;

  // Edge detection. The history flops are cleared by reset, so the first
  // cycle after reset only samples the inputs (armed_q low): a trigger that
  // was already high through reset must fall and rise again to start a run.
  always_comb begin
    trig_hist_d  = trigger;
    react_hist_d = react;
    armed_d      = 1'b1;
    trig_edge    = armed_q & trigger & ~trig_hist_q;
    react_edge   = armed_q & react   & ~react_hist_q;
  end

  // Next-state and datapath logic for the light/delay/reaction sequence.
  always_comb begin
    state_d     = state_q;
    ledr_d      = ledr_q;
    react_ms_d  = react_ms_q;
    valid_d     = 1'b0;
    jump_d      = jump_q;
    step_d      = step_q;
    tick_cnt_d  = tick_cnt_q;
    react_cnt_d = react_cnt_q;
    delay_d     = delay_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_JUMP: begin
        // Start (or restart) clears every result and counter.
        if (trig_edge) begin
          state_d     = ST_LIGHTS;
          ledr_d      = 10'd0;
          react_ms_d  = 14'd0;
          jump_d      = 1'b0;
          step_d      = 4'd0;
          tick_cnt_d  = 14'd0;
          react_cnt_d = 14'd0;
        end
      end

      ST_LIGHTS: begin
        if (tick) begin
          if (tick_cnt_q == LT_LAST) begin
            tick_cnt_d = 14'd0;
            ledr_d     = ledr_q | (10'd1 << step_q);
            step_d     = step_q + 4'd1;
            if (step_q == STEP_LAST) begin
              // Last light on: freeze the random hold time now.
              state_d = ST_DELAY;
              delay_d = MIN_D + {4'd0, lfsr_val};
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 14'd1;
          end
        end
      end

      ST_DELAY: begin
        if (tick) begin
          if (tick_cnt_q == delay_q - 14'd1) begin
            // Lights out: reaction timing starts from zero.
            state_d     = ST_GO;
            ledr_d      = 10'd0;
            tick_cnt_d  = 14'd0;
            react_cnt_d = 14'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 14'd1;
          end
        end
      end

      ST_GO: begin
        // A press wins over a same-cycle tick and reports the count
        // accumulated before this cycle.
        if (react_edge) begin
          state_d    = ST_DONE;
          react_ms_d = react_cnt_q;
          valid_d    = 1'b1;
        end else if (tick) begin
          if (react_cnt_q + 14'd1 >= MAX_R) begin
            state_d     = ST_DONE;
            react_cnt_d = MAX_R;
            react_ms_d  = MAX_R;
            valid_d     = 1'b1;
          end else begin
            react_cnt_d = react_cnt_q + 14'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef F1_JUMP_DETECT_EN
    // A press before lights-out aborts the run, overriding any same-cycle
    // tick progress. react_ms stays at the zero set when the run started.
    if (((state_q == ST_LIGHTS) || (state_q == ST_DELAY)) && react_edge) begin
      state_d = ST_JUMP;
      jump_d  = 1'b1;
      ledr_d  = 10'h3FF;
      valid_d = 1'b0;
    end
`endif
  end

  // State registers with synchronous reset; reset wins over every event.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ledr_q       <= 10'd0;
      react_ms_q   <= 14'd0;
      valid_q      <= 1'b0;
      jump_q       <= 1'b0;
      step_q       <= 4'd0;
      tick_cnt_q   <= 14'd0;
      react_cnt_q  <= 14'd0;
      delay_q      <= 14'd0;
      trig_hist_q  <= 1'b0;
      react_hist_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ledr_q       <= ledr_d;
      react_ms_q   <= react_ms_d;
      valid_q      <= valid_d;
      jump_q       <= jump_d;
      step_q       <= step_d;
      tick_cnt_q   <= tick_cnt_d;
      react_cnt_q  <= react_cnt_d;
      delay_q      <= delay_d;
      trig_hist_q  <= trig_hist_d;
      react_hist_q <= react_hist_d;
      armed_q      <= armed_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy       = (state_q == ST_LIGHTS) || (state_q == ST_DELAY) || (state_q == ST_GO);
    en_lfsr    = (state_q == ST_IDLE) || (state_q == ST_LIGHTS);
    ledr       = ledr_q;
    react_ms   = react_ms_q;
    valid      = valid_q;
    jump_start = jump_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// ---------------------------------------------------------------------------
// tb_f1_start_sequencer
//   Directed scenarios plus a randomized stream, checked against a
//   tick-counting reference model: the model only tracks "ticks since
//   start" and derives lights, hold and reaction from that number.
//   Build with +define+F1_JUMP_DETECT_EN to exercise the jump-start option.
// ---------------------------------------------------------------------------
module tb_f1_start_sequencer;

  localparam int LT = 2;
  localparam int MD = 3;
  localparam int MR = 50;
  localparam int LIGHTS_END = 10 * LT;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_JUMP = 3'd5;
`ifdef F1_JUMP_DETECT_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  // clock / reset / stimulus signals
  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        trigger = 1'b0;
  logic        react = 1'b0;
  logic [9:0]  lfsr_val = 10'd0;
  logic        en_lfsr;
  logic [9:0]  ledr;
  logic [13:0] react_ms;
  logic        valid;
  logic        jump_start;
  logic        busy;
  logic [2:0]  state_dbg;
  logic [27:0] act_vec;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  f1_start_sequencer #(
    .LIGHT_TICKS(LT),
    .MIN_DELAY  (MD),
    .MAX_REACT  (MR)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .tick      (tick),
    .trigger   (trigger),
    .react     (react),
    .lfsr_val  (lfsr_val),
    .en_lfsr   (en_lfsr),
    .ledr      (ledr),
    .react_ms  (react_ms),
    .valid     (valid),
    .jump_start(jump_start),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  assign act_vec = {ledr, busy, valid, react_ms, jump_start, en_lfsr};

  // ---------------- reference model ----------------
  bit         m_busy, m_idle, m_valid, m_jump, m_hist_ok, m_tprev, m_rprev;
  int         m_n, m_d, m_react;
  logic [9:0] m_ledr_hold;

  task automatic model_finish(input int result);
    m_busy  = 1'b0;
    m_valid = 1'b1;
    m_react = result;
  endtask

  task automatic model_step(input logic t, input logic trg, input logic rct,
                            input logic [9:0] lf, input logic r);
    bit te, re, in_go;
    m_valid = 1'b0;
    if (r) begin
      m_busy = 0; m_idle = 1; m_jump = 0; m_hist_ok = 0;
      m_n = 0; m_d = 0; m_react = 0; m_ledr_hold = 10'd0;
      return;
    end
    te = m_hist_ok && trg && !m_tprev;
    re = m_hist_ok && rct && !m_rprev;
    m_tprev = trg; m_rprev = rct; m_hist_ok = 1;
    if (!m_busy) begin
      if (te) begin
        m_busy = 1; m_idle = 0; m_n = 0; m_d = 0;
        m_react = 0; m_jump = 0; m_ledr_hold = 10'd0;
      end
    end else begin
      in_go = (m_n >= LIGHTS_END) && (m_n - LIGHTS_END >= m_d);
      if (in_go && re) begin
        model_finish(m_n - LIGHTS_END - m_d);
      end else if (!in_go && re && JUMP_EN) begin
        m_busy = 0; m_jump = 1; m_ledr_hold = 10'h3FF;
      end else if (t) begin
        m_n++;
        if (m_n == LIGHTS_END) m_d = MD + int'(lf);
        if (m_n >= LIGHTS_END && m_n == LIGHTS_END + m_d + MR) model_finish(MR);
      end
    end
  endtask

  function automatic logic [27:0] exp_vec();
    logic [9:0] l;
    logic       en;
    if (m_busy) begin
      if (m_n < LIGHTS_END) l = 10'((1 << (m_n / LT)) - 1);
      else if (m_n < LIGHTS_END + m_d) l = 10'h3FF;
      else l = 10'd0;
      en = (m_n < LIGHTS_END);
    end else begin
      l  = m_ledr_hold;
      en = m_idle;
    end
    return {l, m_busy, m_valid, 14'(m_react), m_jump, en};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic t, input logic trg, input logic rct,
                             input logic [9:0] lf, input logic r);
    tick = t; trigger = trg; react = rct; lfsr_val = lf; rst = r;
    @(posedge sysclk);
    #1;
    model_step(t, trg, rct, lf, r);
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 10'($urandom_range(0, 1023)), 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 10'($urandom_range(0, 1023)), 1'b1);
    checks++;
    if (act_vec !== 28'h1) begin
      errors++; $display("FAIL reset_outputs actual=%h expected=%h", act_vec, 28'h1);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_state actual=%0d expected=%0d", state_dbg, ST_IDLE);
    end
    // trigger high straight out of reset is not a rising edge
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 10'd0, 1'b0);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL reset_held_trigger actual=%b expected=0", busy);
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic test_lights_and_reaction();
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 10'd5, 1'b0);
    checks++;
    if (act_vec !== {10'h0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL start_outputs actual=%h", act_vec);
    end
    for (int k = 1; k <= 28 + 37; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 10'd5, 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL seq_cycle%0d actual=%h expected=%h", k, act_vec, exp_vec());
      end
      if (k == 2 || k == 20 || k == 28) begin
        checks++;
        if ((k == 2  && {ledr, busy} !== {10'h001, 1'b1}) ||
            (k == 20 && {ledr, busy} !== {10'h3FF, 1'b1}) ||
            (k == 28 && {ledr, busy} !== {10'h000, 1'b1})) begin
          errors++; $display("FAIL lights_tick%0d actual=%h busy=%b", k, ledr, busy);
        end
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 10'd5, 1'b0);
    checks++;
    if (act_vec !== {10'h0, 1'b0, 1'b1, 14'd37, 1'b0, 1'b0} || state_dbg !== ST_DONE) begin
      errors++; $display("FAIL reaction37 actual=%h state=%0d", act_vec, state_dbg);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 10'd5, 1'b0);
    checks++;
    if (act_vec !== {10'h0, 1'b0, 1'b0, 14'd37, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reaction_hold actual=%h", act_vec);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 10'd5, 1'b0);
  endtask

  task automatic test_saturation();
    int vcount;
    logic [9:0] lf;
    lf = 10'($urandom_range(0, 15));
    vcount = 0;
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, lf, 1'b0);
    for (int k = 0; k < 100; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, lf, 1'b0);
      if (valid === 1'b1) vcount++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL sat_cycle%0d actual=%h expected=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (vcount !== 1 || react_ms !== 14'd50 || busy !== 1'b0) begin
      errors++; $display("FAIL saturation valid_pulses=%0d react_ms=%0d busy=%b expected 1/50/0",
                         vcount, react_ms, busy);
    end
  endtask

  task automatic test_react_in_lights();
    int vcount;
    vcount = 0;
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 10'd7, 1'b0);
    for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b0, 1'b0, 10'd7, 1'b0);
    checks++;
    if (ledr !== 10'h007) begin
      errors++; $display("FAIL ledr_seven actual=%h expected=007", ledr);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 10'd7, 1'b0);
    checks++;
`ifdef F1_JUMP_DETECT_EN
    if (act_vec !== {10'h3FF, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0} || state_dbg !== ST_JUMP) begin
      errors++; $display("FAIL jump_entry actual=%h state=%0d", act_vec, state_dbg);
    end
`else
    if (act_vec !== {10'h007, 1'b1, 1'b0, 14'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL react_ignored actual=%h", act_vec);
    end
`endif
    for (int k = 0; k < 150; k++) begin
      drive_cycle(1'b1, (k == 20), 1'b0, 10'd7, 1'b0);
      if (valid === 1'b1) vcount++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL lights_react_cycle%0d actual=%h expected=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (vcount !== 1) begin
      errors++; $display("FAIL lights_react_valid_pulses actual=%0d expected=1", vcount);
    end
  endtask

  task automatic test_reset_mid_delay();
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 10'd5, 1'b0);
    for (int k = 1; k <= 22; k++) drive_cycle(1'b1, (k >= 21), 1'b0, 10'd5, 1'b0);
    checks++;
    if ({ledr, busy, en_lfsr} !== {10'h3FF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL in_delay actual=%h busy=%b en=%b", ledr, busy, en_lfsr);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 10'd5, 1'b1);
    checks++;
    if (act_vec !== 28'h1 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL rst_in_delay actual=%h state=%0d", act_vec, state_dbg);
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 10'd5, 1'b0);
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL no_restart_held actual=%b expected=0", busy);
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 10'd5, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 10'd5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL restart_after_edge actual=%b expected=1", busy);
    end
  endtask

  task automatic test_random();
    logic t, trg, rct, r;
    logic [9:0] lf;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      t   = ($urandom_range(0, 3) != 0);
      trg = ($urandom_range(0, 15) == 0);
      rct = ($urandom_range(0, 24) == 0);
      r   = ($urandom_range(0, 799) == 0);
      lf  = 10'($urandom_range(0, 63));
      drive_cycle(t, trg, rct, lf, r);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d actual=%h expected=%h", k, act_vec, exp_vec());
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_lights_and_reaction();
    test_saturation();
    test_react_in_lights();
    test_reset_mid_delay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f1_start_sequencer.md
F1_START_SEQUENCER -- requirements
Module: f1_start_sequencer

Interface
REQ-001 Parameter LIGHT_TICKS, default 500: ticks between successive LED steps.
REQ-002 Parameter MIN_DELAY, default 200: fixed part of the lights-out random delay, in ticks.
REQ-003 Parameter MAX_REACT, default 9999: reaction-count saturation value, in ticks.
REQ-004 The block SHALL have ports: sysclk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-005 The block SHALL have ports: tick in 1 one-cycle 1 ms strobe; trigger in 1 start request (level); react in 1 driver button (level).
REQ-006 The block SHALL have ports: lfsr_val in 10 pseudo-random value; en_lfsr out 1 LFSR advance enable; ledr out 10 start lights.
REQ-007 The block SHALL have ports: react_ms out 14 reaction result; valid out 1 one-cycle result strobe; jump_start out 1 jump-start flag; busy out 1 sequence in progress.

Function
REQ-008 The block SHALL register trigger and react each cycle; trig_edge/react_edge = input high AND previous-cycle sample low.
REQ-009 The FSM SHALL have states IDLE, LIGHTS, DELAY, GO, DONE, JUMP.
REQ-010 IDLE/DONE/JUMP + trig_edge SHALL transition to LIGHTS next cycle, clearing ledr, react_ms, jump_start, step and tick counters.
REQ-011 trig_edge in LIGHTS, DELAY or GO SHALL be ignored.
REQ-012 In LIGHTS, each tick SHALL increment the tick counter; on the tick where it equals LIGHT_TICKS-1, the counter SHALL reset to 0 and ledr[step] SHALL set, step 0..9 ascending.
REQ-013 On the cycle ledr[9] sets, the FSM SHALL enter DELAY and latch delay_ticks = MIN_DELAY + lfsr_val (14-bit, no overflow).
REQ-014 en_lfsr SHALL be 1 in IDLE and LIGHTS, 0 otherwise, so lfsr_val is frozen from latch onward.
REQ-015 In DELAY, on the tick where the counter equals delay_ticks-1, ledr SHALL clear to 0 and the FSM SHALL enter GO with reaction count 0.
REQ-016 In GO, each tick SHALL increment the reaction count, saturating at MAX_REACT.
REQ-017 react_edge in GO SHALL load react_ms with the current count (pre-increment if tick in same cycle) and enter DONE.
REQ-018 Reaction count reaching MAX_REACT in GO SHALL load react_ms = MAX_REACT and enter DONE.
REQ-019 valid SHALL pulse exactly one cycle, on the cycle DONE is entered; react_ms SHALL hold until the next start.
REQ-020 busy SHALL be 1 in LIGHTS, DELAY, GO; 0 otherwise.
REQ-021 tick absent SHALL freeze all counters; a react_edge without tick SHALL still be acted on the same cycle.

Reset
REQ-022 rst SHALL force IDLE, ledr=0, react_ms=0, valid=0, jump_start=0, busy=0, en_lfsr=1, all counters 0 and edge-detector history 0 on the next sysclk edge.
REQ-023 rst SHALL win over every simultaneous event, including mid-sequence and in the valid cycle.

Configuration
REQ-024 Macro F1_JUMP_DETECT_EN defined: react_edge in LIGHTS or DELAY SHALL enter JUMP, set jump_start=1, set ledr=10'h3FF, leave react_ms=0, no valid.
REQ-025 F1_JUMP_DETECT_EN undefined: react in LIGHTS/DELAY SHALL be ignored, JUMP unreachable, jump_start constant 0.

Verification
REQ-026 LIGHT_TICKS=2, MIN_DELAY=3, lfsr_val=5, tick every cycle, trig pulse -> ledr[0] after 2 ticks, ledr=3FF after 20, ledr=0 after 8 more, busy=1 throughout.
REQ-027 Same setup, react rises 37 ticks after lights out -> valid one cycle, react_ms=37, state DONE, busy=0.
REQ-028 No react in GO, MAX_REACT=50 -> react_ms=50, valid one cycle.
REQ-029 With F1_JUMP_DETECT_EN, react rises while ledr=0x007 -> jump_start=1, ledr=3FF, valid never asserts; retrigger clears jump_start.
REQ-030 rst asserted during DELAY -> next cycle all outputs at reset values, en_lfsr=1; held-high trigger after rst does not restart without a new rising edge.
